// File: rtl/demux_rr_dispatcher_if.sv
// Bundle of the producer-side stream, the per-channel consumer streams and the
// dispatcher status signals.
//   in_valid/in_ready/in_data : single producer stream
//   chan_en                   : per-channel eligibility mask
//   out_valid/out_ready       : per-channel consumer handshake
//   out_data                  : held word, broadcast to every channel
//   cur_sel/busy              : target index of the held word, holding stage occupied
// Modport master is the dispatcher side; slave is the surrounding producer/consumer side.
interface demux_rr_dispatcher_if #(
   parameter int unsigned OUTPUTS    = 8,
   parameter int unsigned SEL_BITS   = $clog2(OUTPUTS),
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic [OUTPUTS-1:0]    chan_en;
   logic [OUTPUTS-1:0]    out_valid;
   logic [OUTPUTS-1:0]    out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [SEL_BITS-1:0]   cur_sel;
   logic                  busy;

   modport master (
      input  in_valid, in_data, chan_en, out_ready,
      output in_ready, out_valid, out_data, cur_sel, busy
   );

   modport slave (
      output in_valid, in_data, chan_en, out_ready,
      input  in_ready, out_valid, out_data, cur_sel, busy
   );
endinterface

// File: rtl/demux_rr_dispatcher.sv
// Round-robin dispatcher: takes one valid/ready stream and hands successive words to
// OUTPUTS consumer channels in rotation, skipping channels whose chan_en bit is clear.
// One word is held in a registered stage; accept-while-draining keeps 1 word/cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : demux_rr_dispatcher_if.master (input stream, channel streams, status)
module demux_rr_dispatcher #(
   parameter int unsigned OUTPUTS    = 8,
   parameter int unsigned SEL_BITS   = $clog2(OUTPUTS),
   parameter int unsigned DATA_WIDTH = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   demux_rr_dispatcher_if.master bus
);

   localparam logic [SEL_BITS-1:0] LastSel = SEL_BITS'(OUTPUTS - 1);

   typedef enum logic [0:0] {StEmpty, StHold} state_e;

   state_e                state_q, state_d;
   logic [SEL_BITS-1:0]   sel_q, sel_d;
   logic [SEL_BITS-1:0]   ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [SEL_BITS-1:0]   start;
   logic [SEL_BITS-1:0]   target;
   logic                  full, any_en, drain, accept;

   // Increment with wrap at OUTPUTS-1 so non-power-of-2 counts never reach index OUTPUTS.
   function automatic logic [SEL_BITS-1:0] wrap_inc(input logic [SEL_BITS-1:0] v);
      return (v == LastSel) ? '0 : v + SEL_BITS'(1);
   endfunction

   assign full   = (state_q == StHold);
   assign any_en = |bus.chan_en;
   assign drain  = full && bus.out_ready[sel_q];
   assign accept = bus.in_valid && bus.in_ready;

   assign bus.in_ready = any_en && (!full || bus.out_ready[sel_q]);
   assign bus.out_data = data_q;
   assign bus.cur_sel  = sel_q;
   assign bus.busy     = full;

   // out_valid comes only from registered state, never from out_ready.
   always_comb begin
      bus.out_valid = '0;
      if (full) bus.out_valid[sel_q] = 1'b1;
   end

   // First enabled channel scanning upward from the pointer; on a same-cycle drain the
   // scan starts just past the draining channel.
   always_comb begin
      logic [SEL_BITS-1:0] idx;
      logic                found;
      start  = drain ? wrap_inc(sel_q) : ptr_q;
      target = start;
      found  = 1'b0;
      idx    = start;
      for (int unsigned i = 0; i < OUTPUTS; i++) begin
         if (!found && bus.chan_en[idx]) begin
            found  = 1'b1;
            target = idx;
         end
         idx = wrap_inc(idx);
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      if (drain) ptr_d = wrap_inc(sel_q);
      if (accept) begin
         sel_d  = target;
         data_d = bus.in_data;
      end
      case (state_q)
         StEmpty: if (accept) state_d = StHold;
         StHold:  if (drain && !accept) state_d = StEmpty;
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StEmpty;
         sel_q   <= '0;
         ptr_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
module tb_demux_rr_dispatcher;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   demux_rr_dispatcher_if #(.OUTPUTS(4), .SEL_BITS(2), .DATA_WIDTH(8)) bus4 ();
   demux_rr_dispatcher_if #(.OUTPUTS(3), .SEL_BITS(2), .DATA_WIDTH(8)) bus3 ();

   demux_rr_dispatcher #(.OUTPUTS(4), .SEL_BITS(2), .DATA_WIDTH(8)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   demux_rr_dispatcher #(.OUTPUTS(3), .SEL_BITS(2), .DATA_WIDTH(8)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   typedef struct {
      logic [3:0] en;
      logic [3:0] rdy;
      logic       vld;
      logic [7:0] din;
      logic       exp_ir;
      logic [3:0] exp_ov;
      logic [1:0] exp_sel;
      logic       exp_busy;
      logic [7:0] exp_dout;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model state for the randomized phase.
   bit         m_held;
   int         m_ch;
   int         m_ptr;
   logic [7:0] m_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive4(input logic [3:0] en, input logic [3:0] rdy, input logic vld,
                         input logic [7:0] din);
      bus4.chan_en   = en;
      bus4.out_ready = rdy;
      bus4.in_valid  = vld;
      bus4.in_data   = din;
   endtask

   task automatic check4(input string tag, input logic ir, input logic [3:0] ov,
                         input logic [1:0] sel, input logic bsy, input logic [7:0] dout);
      chk({tag, " in_ready"},  32'(bus4.in_ready),  32'(ir));
      chk({tag, " out_valid"}, 32'(bus4.out_valid), 32'(ov));
      chk({tag, " cur_sel"},   32'(bus4.cur_sel),   32'(sel));
      chk({tag, " busy"},      32'(bus4.busy),      32'(bsy));
      chk({tag, " out_data"},  32'(bus4.out_data),  32'(dout));
   endtask

   task automatic add(input logic [3:0] en, input logic [3:0] rdy, input logic vld,
                      input logic [7:0] din, input logic ir, input logic [3:0] ov,
                      input logic [1:0] sel, input logic bsy, input logic [7:0] dout);
      vec_t v;
      v.en = en; v.rdy = rdy; v.vld = vld; v.din = din;
      v.exp_ir = ir; v.exp_ov = ov; v.exp_sel = sel; v.exp_busy = bsy; v.exp_dout = dout;
      vecs.push_back(v);
   endtask

   initial begin
      // Round-robin sweep A0..A7 over all four channels, all ready.
      add(4'hF, 4'hF, 1'b1, 8'hA0, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h00);
      for (int k = 1; k < 8; k++)
         add(4'hF, 4'hF, 1'b1, 8'(8'hA0 + k), 1'b1, 4'(1 << ((k - 1) % 4)),
             2'((k - 1) % 4), 1'b1, 8'(8'hA0 + k - 1));
      add(4'hF, 4'hF, 1'b0, 8'h00, 1'b1, 4'b1000, 2'd3, 1'b1, 8'hA7);
      add(4'hF, 4'hF, 1'b0, 8'h00, 1'b1, 4'b0000, 2'd3, 1'b0, 8'hA7);
      // Skip disabled channels 0 and 2.
      add(4'b1010, 4'hF, 1'b1, 8'hB0, 1'b1, 4'b0000, 2'd3, 1'b0, 8'hA7);
      add(4'b1010, 4'hF, 1'b1, 8'hB1, 1'b1, 4'b0010, 2'd1, 1'b1, 8'hB0);
      add(4'b1010, 4'hF, 1'b1, 8'hB2, 1'b1, 4'b1000, 2'd3, 1'b1, 8'hB1);
      add(4'b1010, 4'hF, 1'b1, 8'hB3, 1'b1, 4'b0010, 2'd1, 1'b1, 8'hB2);
      add(4'b1010, 4'hF, 1'b0, 8'h00, 1'b1, 4'b1000, 2'd3, 1'b1, 8'hB3);
      add(4'b1010, 4'hF, 1'b0, 8'h00, 1'b1, 4'b0000, 2'd3, 1'b0, 8'hB3);

      // Reset state.
      rst_n = 1'b0;
      drive4(4'h0, 4'h0, 1'b0, 8'h00);
      bus3.chan_en = '0; bus3.out_ready = '0; bus3.in_valid = 1'b0; bus3.in_data = '0;
      #1;
      check4("reset", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);
      drive4(4'hF, 4'h0, 1'b0, 8'h00);
      #1;
      chk("reset in_ready en", 32'(bus4.in_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive4(vecs[i].en, vecs[i].rdy, vecs[i].vld, vecs[i].din);
         #1;
         check4($sformatf("vec%0d", i), vecs[i].exp_ir, vecs[i].exp_ov, vecs[i].exp_sel,
                vecs[i].exp_busy, vecs[i].exp_dout);
         @(negedge clk);
      end

      // Back-pressure on channel 2 for five cycles.
      drive4(4'hF, 4'b1011, 1'b1, 8'hC0); #1; check4("bp0", 1, 4'b0000, 3, 0, 8'hB3);
      @(negedge clk);
      drive4(4'hF, 4'b1011, 1'b1, 8'hC1); #1; check4("bp1", 1, 4'b0001, 0, 1, 8'hC0);
      @(negedge clk);
      drive4(4'hF, 4'b1011, 1'b1, 8'hC2); #1; check4("bp2", 1, 4'b0010, 1, 1, 8'hC1);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         drive4(4'hF, 4'b1011, 1'b1, 8'hC3); #1;
         check4($sformatf("bp_hold%0d", c), 0, 4'b0100, 2, 1, 8'hC2);
         @(negedge clk);
      end
      drive4(4'hF, 4'hF, 1'b1, 8'hC3); #1; check4("bp_drain", 1, 4'b0100, 2, 1, 8'hC2);
      @(negedge clk);
      drive4(4'hF, 4'hF, 1'b0, 8'h00); #1; check4("bp_next", 1, 4'b1000, 3, 1, 8'hC3);
      @(negedge clk);
      drive4(4'hF, 4'hF, 1'b0, 8'h00); #1; check4("bp_idle", 1, 4'b0000, 3, 0, 8'hC3);
      @(negedge clk);

      // Mask change while holding for channel 1.
      drive4(4'hF, 4'b1101, 1'b1, 8'hD0); #1; check4("mk0", 1, 4'b0000, 3, 0, 8'hC3);
      @(negedge clk);
      drive4(4'hF, 4'b1101, 1'b1, 8'hD1); #1; check4("mk1", 1, 4'b0001, 0, 1, 8'hD0);
      @(negedge clk);
      drive4(4'hF, 4'b1101, 1'b0, 8'h00); #1; check4("mk2", 0, 4'b0010, 1, 1, 8'hD1);
      @(negedge clk);
      drive4(4'b0001, 4'b1101, 1'b0, 8'h00); #1; check4("mk3", 0, 4'b0010, 1, 1, 8'hD1);
      @(negedge clk);
      drive4(4'b0001, 4'b1101, 1'b1, 8'hD2); #1; check4("mk4", 0, 4'b0010, 1, 1, 8'hD1);
      @(negedge clk);
      drive4(4'b0001, 4'hF, 1'b1, 8'hD2); #1; check4("mk5", 1, 4'b0010, 1, 1, 8'hD1);
      @(negedge clk);
      drive4(4'b0001, 4'hF, 1'b0, 8'h00); #1; check4("mk6", 1, 4'b0001, 0, 1, 8'hD2);
      @(negedge clk);
      drive4(4'b0001, 4'hF, 1'b0, 8'h00); #1; check4("mk7", 1, 4'b0000, 0, 0, 8'hD2);
      @(negedge clk);

      // All channels disabled, then re-enable channel 2 only.
      for (int c = 0; c < 6; c++) begin
         drive4(4'h0, 4'hF, 1'b1, 8'hE0); #1;
         check4($sformatf("dis%0d", c), 0, 4'b0000, 0, 0, 8'hD2);
         @(negedge clk);
      end
      drive4(4'b0100, 4'hF, 1'b1, 8'hE0); #1; check4("en0", 1, 4'b0000, 0, 0, 8'hD2);
      @(negedge clk);
      drive4(4'b0100, 4'hF, 1'b0, 8'h00); #1; check4("en1", 1, 4'b0100, 2, 1, 8'hE0);
      @(negedge clk);
      drive4(4'b0100, 4'hF, 1'b0, 8'h00); #1; check4("en2", 1, 4'b0000, 2, 0, 8'hE0);
      @(negedge clk);

      // Asynchronous reset while holding a word.
      drive4(4'hF, 4'h0, 1'b1, 8'hF0); #1; check4("rs0", 1, 4'b0000, 2, 0, 8'hE0);
      @(negedge clk);
      drive4(4'hF, 4'h0, 1'b0, 8'h00); #1; check4("rs1", 0, 4'b1000, 3, 1, 8'hF0);
      rst_n = 1'b0;
      #1;
      check4("rs_async", 1, 4'b0000, 0, 0, 8'h00);
      @(negedge clk);
      check4("rs_held", 1, 4'b0000, 0, 0, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      drive4(4'hF, 4'hF, 1'b1, 8'hF1); #1; check4("rs2", 1, 4'b0000, 0, 0, 8'h00);
      @(negedge clk);
      drive4(4'hF, 4'hF, 1'b0, 8'h00); #1; check4("rs3", 1, 4'b0001, 0, 1, 8'hF1);
      @(negedge clk);

      // Randomized traffic against the reference model, from a fresh reset.
      rst_n = 1'b0;
      drive4(4'h0, 4'h0, 1'b0, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      m_held = 1'b0; m_ch = 0; m_ptr = 0; m_data = 8'h00;
      for (int c = 0; c < 400; c++) begin
         logic [3:0] en, rdy;
         logic       vld, exp_ir, drain;
         logic [7:0] din;
         en  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         rdy = 4'($urandom_range(0, 15));
         vld = ($urandom_range(0, 3) != 0);
         din = 8'($urandom_range(0, 255));
         drive4(en, rdy, vld, din);
         #1;
         exp_ir = (en != 4'h0) && (!m_held || rdy[m_ch]);
         check4($sformatf("rnd%0d", c), exp_ir, m_held ? 4'(1 << m_ch) : 4'b0000,
                2'(m_ch), m_held, m_data);
         drain = m_held && rdy[m_ch];
         if (drain) m_ptr = (m_ch + 1) % 4;
         if (vld && exp_ir) begin
            for (int j = 3; j >= 0; j--)
               if (en[(m_ptr + j) % 4]) m_ch = (m_ptr + j) % 4;
            m_held = 1'b1;
            m_data = din;
         end else if (drain) begin
            m_held = 1'b0;
         end
         @(negedge clk);
      end
      drive4(4'h0, 4'h0, 1'b0, 8'h00);

      // Three-channel instance: wrap at 2, index 3 never appears.
      for (int i = 0; i < 9; i++) begin
         bus3.chan_en   = 3'b111;
         bus3.out_ready = 3'b111;
         bus3.in_valid  = (i < 7);
         bus3.in_data   = 8'(8'h30 + i);
         #1;
         if (i > 0 && i < 8) begin
            chk($sformatf("np2_%0d out_valid", i), 32'(bus3.out_valid),
                32'(1 << ((i - 1) % 3)));
            chk($sformatf("np2_%0d cur_sel", i), 32'(bus3.cur_sel), 32'((i - 1) % 3));
            chk($sformatf("np2_%0d out_data", i), 32'(bus3.out_data), 32'(8'h30 + i - 1));
         end
         if (i == 8) chk("np2 idle busy", 32'(bus3.busy), 32'd0);
         chk($sformatf("np2_%0d in_ready", i), 32'(bus3.in_ready), 32'd1);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/demux_rr_dispatcher.md
Name: demux_rr_dispatcher

Overview:
- Sequencing controller for the parametric demultiplexer datapath.
- Accepts one valid/ready input stream and distributes successive words round-robin across OUTPUTS valid/ready output channels.
- Skips disabled channels and holds one word in a registered stage.
- Sits between a single producer and a bank of parallel consumers (worker lanes, FIFOs).

Parameters:
- OUTPUTS, 8: number of output channels; must be ≥ 2.
- SEL_BITS, $clog2(OUTPUTS): width of channel index.
- DATA_WIDTH, 8: width of each data word.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  dispatcher accepts the word this cycle.
- in_data  input  DATA_WIDTH  input word.
- chan_en  input  OUTPUTS  per-channel enable mask; bit k=1 means channel k is eligible.
- out_valid  output  OUTPUTS  one-hot (or zero) valid, one bit per channel.
- out_ready  input  OUTPUTS  per-channel consumer ready.
- out_data  output  DATA_WIDTH  held word, broadcast to all channels; qualified by out_valid.
- cur_sel  output  SEL_BITS  index of the channel targeted by the held word.
- busy  output  1  holding register occupied.

Behaviour:
- Reset (rst_n low, asynchronous) forces the following state:
  - full=0, out_valid=0, out_data=0, cur_sel=0, busy=0.
  - Round-robin pointer ptr=0.
  - in_ready is combinational and therefore 0 only if chan_en==0.
- States:
  - EMPTY (full=0): nothing held.
  - HOLD (full=1): word held; out_valid[cur_sel]=1, all other out_valid bits 0.
- Target selection happens only at capture.
  - Target is the first k in ptr, ptr+1, …, ptr+OUTPUTS-1 (mod OUTPUTS) with chan_en[k]=1.
  - Target is latched into cur_sel.
  - Target never changes while in HOLD, even if chan_en changes.
- Drain: in HOLD, the word drains in the cycle where out_ready[cur_sel]=1. On drain, ptr ← cur_sel+1, wrapping OUTPUTS-1 → 0.
  - Ready from non-target channels is ignored.
- in_ready = (chan_en≠0) && (!full || out_ready[cur_sel]).
  - Accept-while-draining is required, giving 1 word/cycle sustained throughput.
  - On a simultaneous drain and accept, selection for the new word starts from the updated pointer (cur_sel+1).
- Transitions:
  - EMPTY→HOLD on accept.
  - HOLD→HOLD on drain+accept.
  - HOLD→EMPTY on drain with no accept.
  - Otherwise the state holds.
- Latency: a word accepted in cycle N appears on out_valid/out_data in cycle N+1.
- Valid/ready compliance:
  - out_valid never depends combinationally on out_ready.
  - Once asserted, out_valid and out_data stay stable until drain.
- out_data updates only on accept; it retains its last value when EMPTY.
- busy=full.
- chan_en==0: in_ready=0 and no capture. A word already held still drains normally.
- OUTPUTS not a power of 2: the pointer wraps at OUTPUTS-1, and index values ≥ OUTPUTS never appear on cur_sel.
- Reset asserted mid-HOLD discards the held word immediately (asynchronous); no output pulse follows.

Test Plan:
- Round-robin sweep: OUTPUTS=4, chan_en=4'b1111, out_ready all 1, send 0xA0..0xA7 back-to-back. Required:
  - in_ready stays 1.
  - Words appear on channels 0,1,2,3,0,1,2,3, one per cycle, each 1 cycle after acceptance.
- Skip disabled: chan_en=4'b1010, send 4 words. Required: channels 1,3,1,3; out_valid[0] and out_valid[2] never asserted.
- Back-pressure: target channel 2 holds out_ready[2]=0 for 5 cycles while the others are ready. Required:
  - out_valid[2]=1 with stable out_data for all 5 cycles.
  - in_ready=0 throughout.
  - Drain on cycle 6, next word goes to channel 3.
- Mask change while holding: word held for channel 1, chan_en changes to 4'b0001. Required: word still drains on channel 1, next word goes to channel 0.
- All disabled: chan_en=0, in_valid=1. Required: in_ready=0, busy=0, out_valid=0 indefinitely. Re-enabling 4'b0100 routes the word to channel 2.
- Reset mid-operation: pull rst_n low asynchronously while busy=1. Required:
  - out_valid=0 and busy=0 immediately.
  - After release, the first word goes to channel 0.
- Non-power-of-2: OUTPUTS=3, 7 words. Required: channels 0,1,2,0,1,2,0; cur_sel never reaches 3.
